// File: rtl/stream_demux_n_if.sv
// Stream demultiplexer bus bundle.
//   Upstream: in_valid/in_ready/in_data/in_sel/in_bcast (single producer).
//   Downstream: out_valid/out_ready/out_data, one lane per channel;
//   channel k occupies out_data[k*DATA_W +: DATA_W].
// Modports:
//   master - environment side: drives the producer beat and the consumer readies.
//   slave  - demux side: drives in_ready and the per-channel outputs.
interface stream_demux_n_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with broadcast.
// Each input beat goes to the channel picked by in_sel, or to every channel
// when in_bcast is set. Every channel has a one-entry holding register with
// its own valid/ready handshake. Beats with an out-of-range select are
// consumed without delivery and counted.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   bus         - stream_demux_n_if.slave (input beat + per-channel outputs)
//   sel_err_cnt - saturating count of dropped out-of-range beats
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_n_if.slave  bus,
  output logic [ERR_W-1:0] sel_err_cnt
);

  logic [N_OUT-1:0]  valid_reg;
  logic [DATA_W-1:0] data_reg [N_OUT];
  logic [ERR_W-1:0]  err_cnt_reg;

  logic [N_OUT-1:0]  target;
  logic [N_OUT-1:0]  free;
  logic [N_OUT-1:0]  blocked;
  logic              accept;
  logic              sel_bad;
  logic [N_OUT*DATA_W-1:0] out_data_flat;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_chan
      localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);

      // No channel matches an out-of-range select, so its mask is all zero.
      assign target[gi]  = bus.in_bcast | (bus.in_sel == IDX);
      // A slot draining this cycle can be refilled in the same cycle.
      assign free[gi]    = ~valid_reg[gi] | bus.out_ready[gi];
      assign blocked[gi] = target[gi] & ~free[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (accept && target[gi]) begin
          // Load has priority over a concurrent drain.
          valid_reg[gi] <= 1'b1;
          data_reg[gi]  <= bus.in_data;
        end else if (valid_reg[gi] && bus.out_ready[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      // A stalled beat must hold still until taken.
      a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_reg[gi] && !bus.out_ready[gi]) |=> (valid_reg[gi] && $stable(data_reg[gi])));
    end
  endgenerate

  // Broadcast is all-or-nothing: any blocked target channel stalls the beat.
  assign bus.in_ready = ~|blocked;
  assign accept       = bus.in_valid & bus.in_ready;
  assign sel_bad      = ~bus.in_bcast & ~|target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (accept && sel_bad && (err_cnt_reg != {ERR_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    out_data_flat = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_data_flat[k*DATA_W +: DATA_W] = data_reg[k];
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_data  = out_data_flat;
  assign sel_err_cnt   = err_cnt_reg;

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_ready |-> ~|(target & valid_reg & ~bus.out_ready));

endmodule
